spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave (responder) end of the team's 8-bit SPI link: receives MSB-first bytes from an
//  external master on spi_mosi and returns bytes on spi_miso, in any of SPI modes 0-3.
//  Samples spi_sclk/spi_cs_n/spi_mosi in the system clock domain (oversampled).
//  Connects to an 8-bit system bus via a one-entry TX holding register and a pulsed RX strobe.
// PARAMETERS
//  mode        0        SPI mode: CPOL = (mode==2|mode==3), CPHA = (mode==1|mode==3)
//  DEFAULT_TX  8'h00    byte shifted out when no TX byte is buffered at a byte start
// PORTS
//  clock        in   1  system clock; frequency >= 8x spi_sclk
//  reset        in   1  asynchronous, active-low reset
//  spi_sclk     in   1  SPI clock from master (asynchronous)
//  spi_cs_n     in   1  chip select from master, active low (asynchronous)
//  spi_mosi     in   1  serial data from master
//  spi_miso     out  1  serial data to master
//  spi_miso_oe  out  1  MISO output enable (1 while selected)
//  tx_data      in   8  byte to send to master
//  tx_load      in   1  write strobe for tx_data; accepted only when tx_ready=1
//  tx_ready     out  1  1 = TX holding register empty
//  rx_data      out  8  last complete byte received from master
//  rx_valid     out  1  one-cycle pulse: rx_data updated
//  tx_underrun  out  1  one-cycle pulse: byte start with empty holding register
//  busy         out  1  1 while a frame is active (synchronized CS low)
// BEHAVIOUR
//  - Reset (async, reset=0): spi_miso=0, spi_miso_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=1,
//    tx_underrun=0, busy=0, state=IDLE, bit counter=7, shift registers cleared.
//  - Sync: spi_sclk, spi_cs_n, spi_mosi each pass a 2-flop synchronizer; a 3rd flop on sclk/cs_n
//    gives edge detection. All actions below occur on the clock after the synchronized edge.
//  - Edges: leading = sclk leaving CPOL level; trailing = sclk returning to CPOL level.
//    Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
//  - States: IDLE -> ACTIVE on synced cs_n falling; ACTIVE -> IDLE on synced cs_n rising.
//    sclk edges are ignored in IDLE.
//  - Byte start (cs_n fall, and after every 8th sample while ACTIVE): if tx_ready=0, the holding
//    register moves into the TX shifter and tx_ready=1 that cycle; else shifter<=DEFAULT_TX and
//    tx_underrun pulses for 1 cycle.
//  - MISO: CPHA=0: spi_miso<=shifter[7] at byte start, next bit on each trailing edge.
//    CPHA=1: spi_miso<=next bit (bit7 first) on each leading edge. spi_miso_oe = busy.
//  - RX: on each sample edge, rx shifter <= {rx_shift[6:0], mosi_sync}; counter decrements 7->0.
//    On the 8th sample: rx_data<=full byte, rx_valid=1 for exactly 1 cycle, counter wraps to 7,
//    byte start follows next cycle. Latency pin sample edge -> rx_valid <= 4 clock cycles.
//  - TX handshake: tx_load & tx_ready -> capture tx_data, tx_ready=0 next cycle.
//    tx_load while tx_ready=0 -> ignored, held byte unchanged. tx_load in the same cycle as a
//    byte start that frees the register: the register is freed first, then the new byte captured.
//  - Abort: cs_n rising mid-byte -> partial RX discarded, no rx_valid, counter=7, spi_miso=0,
//    spi_miso_oe=0; the byte already in the TX shifter is dropped; holding register untouched.
//  - cs_n rising on the same cycle as the 8th sample: rx_valid still issued, no new byte start.
//  - Async reset mid-frame: immediate return to reset values; the next frame needs a fresh cs_n fall.
// TESTING
//  1 mode=0, tx_load 8'hA5 before CS, master sends 8'h3C -> master reads 8'hA5; rx_data=8'h3C, rx_valid 1 pulse
//  2 modes 1,2,3 each: load 8'h81, master sends 8'h7E -> reads 8'h81; rx_data=8'h7E
//  3 no tx_load, DEFAULT_TX=8'hFF, 2-byte frame 8'h12,8'h34 -> MISO 8'hFF,8'hFF; 2 underrun, 2 rx_valid pulses
//  4 load 8'h11; load 8'h22 while tx_ready=0 -> 2nd ignored; 2-byte frame returns 8'h11 then DEFAULT_TX
//  5 CS raised after 5 bits of 8'hC3 -> no rx_valid, rx_data unchanged, spi_miso_oe=0 within 4 clocks
//  6 reset=0 mid-byte -> all outputs at reset values same cycle; next full frame receives 8'h5A

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI responder for the 8-bit link: oversamples SCLK/CS_n/MOSI in the system clock domain,
// shifts bytes MSB-first in any SPI mode and hands them to a simple 8-bit bus.
module spi_slave_if #(
  parameter int unsigned mode       = 0,
  parameter logic [7:0]  DEFAULT_TX = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic Cpol = (mode == 2) || (mode == 3);
  localparam logic Cpha = (mode == 1) || (mode == 3);

  typedef enum logic {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [2:0]  cs_q, cs_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic        underrun_q, underrun_d;
  logic        miso_q, miso_d;
  logic        start_pend_q, start_pend_d;

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic       cs_fall, cs_rise, byte_start, tx_free;
  logic [7:0] next_byte;

  always_comb begin
    sclk_d       = {sclk_q[1:0], spi_sclk};
    cs_d         = {cs_q[1:0], spi_cs_n};
    mosi_d       = {mosi_q[0], spi_mosi};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    rx_data_d    = rx_data_q;
    tx_ready_d   = tx_ready_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    miso_d       = miso_q;
    start_pend_d = 1'b0;
    byte_start   = 1'b0;
    next_byte    = DEFAULT_TX;
    tx_free      = tx_ready_q;

    sclk_rise   = sclk_q[1] & ~sclk_q[2];
    sclk_fall   = ~sclk_q[1] & sclk_q[2];
    lead_edge   = Cpol ? sclk_fall : sclk_rise;
    trail_edge  = Cpol ? sclk_rise : sclk_fall;
    sample_edge = Cpha ? trail_edge : lead_edge;
    shift_edge  = Cpha ? lead_edge : trail_edge;
    cs_fall     = ~cs_q[1] & cs_q[2];
    cs_rise     = cs_q[1] & ~cs_q[2];

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StActive;
          bit_cnt_d  = 3'd7;
          rx_shift_d = 8'h00;
          byte_start = 1'b1;
        end
      end
      StActive: begin
        if (sample_edge) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
          if (bit_cnt_q == 3'd0) begin
            rx_data_d    = {rx_shift_q[6:0], mosi_q[1]};
            rx_valid_d   = 1'b1;
            bit_cnt_d    = 3'd7;
            start_pend_d = ~cs_rise;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        // In CPHA=0 the trailing edge after the 8th sample must not disturb the
        // bit 7 already presented by the following byte start.
        if (shift_edge && (Cpha || (bit_cnt_q != 3'd7))) begin
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        byte_start = start_pend_q & ~cs_rise;
        if (cs_rise) begin
          state_d      = StIdle;
          bit_cnt_d    = 3'd7;
          rx_shift_d   = 8'h00;
          tx_shift_d   = 8'h00;
          miso_d       = 1'b0;
          start_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (byte_start) begin
      if (!tx_ready_q) begin
        next_byte  = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
      if (Cpha) begin
        tx_shift_d = next_byte;
      end else begin
        miso_d     = next_byte[7];
        tx_shift_d = {next_byte[6:0], 1'b0};
      end
      tx_free = 1'b1;
    end

    // A byte start empties the holding register before a same-cycle load is considered.
    if (tx_load && tx_free) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sclk_q       <= {3{Cpol}};
      cs_q         <= 3'b111;
      mosi_q       <= 2'b00;
      bit_cnt_q    <= 3'd7;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      hold_q       <= 8'h00;
      rx_data_q    <= 8'h00;
      tx_ready_q   <= 1'b1;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      miso_q       <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      rx_data_q    <= rx_data_d;
      tx_ready_q   <= tx_ready_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      miso_q       <= miso_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign spi_miso    = miso_q;
  assign busy        = (state_q == StActive);
  assign spi_miso_oe = busy;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: one instance per SPI mode, driven by a bit-banged master.
module tb_spi_slave_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] sclk, cs_n, tx_load;
  logic       mosi;
  logic [7:0] tx_data;
  logic [3:0] miso, oe, tx_ready, rx_valid, underrun, busy;
  logic [7:0] rx_data [4];

  int n_checks = 0;
  int n_errors = 0;
  int rxv_cnt [4]    = '{default: 0};
  int und_cnt [4]    = '{default: 0};
  int und_at_rxv [4] = '{default: 0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [7:0] Dflt = (g == 0) ? 8'hFF : 8'h00;
    spi_slave_if #(.mode(g), .DEFAULT_TX(Dflt)) u_dut (
      .clock      (clk),
      .reset      (rst_n),
      .spi_sclk   (sclk[g]),
      .spi_cs_n   (cs_n[g]),
      .spi_mosi   (mosi),
      .spi_miso   (miso[g]),
      .spi_miso_oe(oe[g]),
      .tx_data    (tx_data),
      .tx_load    (tx_load[g]),
      .tx_ready   (tx_ready[g]),
      .rx_data    (rx_data[g]),
      .rx_valid   (rx_valid[g]),
      .tx_underrun(underrun[g]),
      .busy       (busy[g])
    );
  end

  // Pulse counters; und_at_rxv records the underrun count seen when rx_valid fires.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        rxv_cnt[i]    <= rxv_cnt[i] + 1;
        und_at_rxv[i] <= und_cnt[i];
      end
      if (underrun[i]) und_cnt[i] <= und_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_data    = b;
    tx_load[m] = 1'b1;
    @(negedge clk);
    tx_load[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high(input int m);
    wait_clk(8);
    cs_n[m] = 1'b1;
    wait_clk(8);
  endtask

  // Master shifts nbits of b MSB-first and collects MISO at its own sample edges.
  task automatic xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] r);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m == 1) || (m == 3);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = b[i];
        wait_clk(8);
        r = {r[6:0], miso[m]};
        sclk[m] = ~cpol;
        wait_clk(8);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = b[i];
        wait_clk(8);
        r = {r[6:0], miso[m]};
        sclk[m] = cpol;
        wait_clk(8);
      end
    end
  endtask

  initial begin
    logic [7:0] rd, rd2;
    int rxv_base, und_base;

    rst_n   = 1'b0;
    sclk    = 4'b1100;
    cs_n    = 4'hF;
    tx_load = 4'h0;
    mosi    = 1'b0;
    tx_data = 8'h00;
    wait_clk(3);
    #1;
    check("rst_miso", miso[0], 1'b0);
    check("rst_oe", oe[0], 1'b0);
    check("rst_rx_data", rx_data[0], 8'h00);
    check("rst_rx_valid", rx_valid[0], 1'b0);
    check("rst_tx_ready", tx_ready, 4'hF);
    check("rst_underrun", underrun[0], 1'b0);
    check("rst_busy", busy, 4'h0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0 single byte with a preloaded TX byte
    rxv_base = rxv_cnt[0];
    und_base = und_cnt[0];
    load(0, 8'hA5);
    check("t1_tx_ready_loaded", tx_ready[0], 1'b0);
    cs_low(0);
    check("t1_busy", busy[0], 1'b1);
    check("t1_oe", oe[0], 1'b1);
    xfer(0, 8'h3C, 8, rd);
    cs_high(0);
    check("t1_miso_byte", rd, 8'hA5);
    check("t1_rx_data", rx_data[0], 8'h3C);
    check("t1_rx_valid_pulses", rxv_cnt[0] - rxv_base, 1);
    check("t1_no_underrun", und_at_rxv[0] - und_base, 0);
    check("t1_tx_ready_freed", tx_ready[0], 1'b1);
    check("t1_idle", busy[0], 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      rxv_base = rxv_cnt[m];
      load(m, 8'h81);
      cs_low(m);
      xfer(m, 8'h7E, 8, rd);
      cs_high(m);
      check($sformatf("t2_m%0d_miso_byte", m), rd, 8'h81);
      check($sformatf("t2_m%0d_rx_data", m), rx_data[m], 8'h7E);
      check($sformatf("t2_m%0d_rx_valid", m), rxv_cnt[m] - rxv_base, 1);
    end

    // Two-byte frame with nothing loaded: DEFAULT_TX (FF) for both bytes
    rxv_base = rxv_cnt[0];
    und_base = und_cnt[0];
    cs_low(0);
    xfer(0, 8'h12, 8, rd);
    check("t3_rx_data_b1", rx_data[0], 8'h12);
    xfer(0, 8'h34, 8, rd2);
    cs_high(0);
    check("t3_miso_b1", rd, 8'hFF);
    check("t3_miso_b2", rd2, 8'hFF);
    check("t3_rx_valid_pulses", rxv_cnt[0] - rxv_base, 2);
    check("t3_underruns", und_at_rxv[0] - und_base, 2);
    check("t3_rx_data_b2", rx_data[0], 8'h34);

    // Second load while full is ignored
    und_base = und_cnt[0];
    load(0, 8'h11);
    load(0, 8'h22);
    check("t4_tx_ready_held", tx_ready[0], 1'b0);
    cs_low(0);
    xfer(0, 8'h55, 8, rd);
    xfer(0, 8'hAA, 8, rd2);
    cs_high(0);
    check("t4_miso_b1", rd, 8'h11);
    check("t4_miso_b2", rd2, 8'hFF);
    check("t4_underruns", und_at_rxv[0] - und_base, 1);
    check("t4_rx_data", rx_data[0], 8'hAA);

    // Abort after 5 bits
    rxv_base = rxv_cnt[0];
    cs_low(0);
    xfer(0, 8'hC3, 5, rd);
    cs_n[0] = 1'b1;
    wait_clk(4);
    check("t5_oe_off", oe[0], 1'b0);
    check("t5_busy_off", busy[0], 1'b0);
    check("t5_miso_low", miso[0], 1'b0);
    wait_clk(8);
    check("t5_no_rx_valid", rxv_cnt[0] - rxv_base, 0);
    check("t5_rx_data_kept", rx_data[0], 8'hAA);

    // Async reset mid-byte, then a fresh frame
    cs_low(0);
    xfer(0, 8'hF0, 4, rd);
    load(0, 8'h77);
    check("t6_tx_ready_loaded", tx_ready[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso", miso[0], 1'b0);
    check("t6_rst_oe", oe[0], 1'b0);
    check("t6_rst_busy", busy[0], 1'b0);
    check("t6_rst_rx_data", rx_data[0], 8'h00);
    check("t6_rst_tx_ready", tx_ready[0], 1'b1);
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    rxv_base = rxv_cnt[0];
    cs_low(0);
    xfer(0, 8'h5A, 8, rd);
    cs_high(0);
    check("t6_rx_data", rx_data[0], 8'h5A);
    check("t6_rx_valid", rxv_cnt[0] - rxv_base, 1);
    check("t6_miso_default", rd, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
